// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction field offsets for the multi-cycle CPU.
// Field offsets are functions so every user derives them from its own REG_BITS/DATA_WIDTH.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_MOVI = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Instruction layout, MSB first: {opcode[4], rd, rs1, rs2, imm[data_width]}
  function automatic int opc_lsb(input int reg_bits, input int data_width);
    return 3 * reg_bits + data_width;
  endfunction

  function automatic int rd_lsb(input int reg_bits, input int data_width);
    return 2 * reg_bits + data_width;
  endfunction

  function automatic int rs1_lsb(input int reg_bits, input int data_width);
    return reg_bits + data_width;
  endfunction

  function automatic int rs2_lsb(input int reg_bits, input int data_width);
    return (reg_bits * 0) + data_width;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: returns {carry, result}; carry is the extra sum bit, i.e. borrow for SUB.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH:0]   res
);

  logic [2:0] sh;
  assign sh = imm[2:0];

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_SHL:  res = {1'b0, a << sh};
      OP_SHR:  res = {1'b0, a >> sh};
      OP_ADDI: res = {1'b0, a} + {1'b0, imm};
      OP_MOVI: res = {1'b0, imm};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: one instruction in flight, FETCH/DECODE/EXEC/MEM/WB sequencing over
// an internal register file and data memory, with retire/flag reporting and a debug view.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int REG_BITS   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [4+3*REG_BITS+DATA_WIDTH-1:0]   instr,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic [REG_BITS-1:0]                  dbg_sel,
  output logic [DATA_WIDTH-1:0]                dbg_data,
  output logic                                 retire,
  output logic [DATA_WIDTH-1:0]                result,
  output logic                                 zero,
  output logic                                 carry,
  output logic                                 halted,
  output state_t                               dbg_state
);

  localparam int INSTR_WIDTH = 4 + 3 * REG_BITS + DATA_WIDTH;
  localparam int OPC_LSB     = opc_lsb(REG_BITS, DATA_WIDTH);
  localparam int RD_LSB      = rd_lsb(REG_BITS, DATA_WIDTH);
  localparam int RS1_LSB     = rs1_lsb(REG_BITS, DATA_WIDTH);
  localparam int RS2_LSB     = rs2_lsb(REG_BITS, DATA_WIDTH);

  state_t state, state_nx;

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0]  op_a, op_b, result_q;
  logic [DATA_WIDTH-1:0]  regs [2**REG_BITS];
  logic [DATA_WIDTH-1:0]  mem  [2**ADDR_BITS];
  logic                   zero_q, carry_q, run_q, halt_seen;

  logic [3:0]            op;
  logic [REG_BITS-1:0]   rd, rs1, rs2;
  logic [DATA_WIDTH-1:0] imm, addr_sum;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH:0]   alu_res;
  logic                  wr_en;

  assign op       = instr_q[OPC_LSB +: 4];
  assign rd       = instr_q[RD_LSB +: REG_BITS];
  assign rs1      = instr_q[RS1_LSB +: REG_BITS];
  assign rs2      = instr_q[RS2_LSB +: REG_BITS];
  assign imm      = instr_q[DATA_WIDTH-1:0];
  assign addr_sum = op_a + imm;
  assign mem_addr = ADDR_BITS'(addr_sum);
  assign wr_en    = (op <= OP_ADDI) || (op == OP_LD) || (op == OP_MOVI);

  cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op  (op),
    .a   (op_a),
    .b   (op_b),
    .imm (imm),
    .res (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (instr_valid && instr_ready) state_nx = DECODE;
      DECODE:  state_nx = (op == OP_HALT) ? HALT : EXEC;
      EXEC:    state_nx = ((op == OP_LD) || (op == OP_ST)) ? MEM : WB;
      MEM:     state_nx = WB;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  // Handshake: a word transfers on a rising edge where instr_valid && instr_ready are both
  // high; ready is only offered in FETCH, so the source holds instr until that edge.
  always_comb begin
    instr_ready = (state == FETCH) && run_q;
    retire      = (state == WB) || ((state == HALT) && !halt_seen);
    halted      = (state == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      run_q     <= 1'b0;
      halt_seen <= 1'b0;
      for (int i = 0; i < 2**REG_BITS; i++) regs[i] <= '0;
    end else begin
      run_q <= 1'b1;
      case (state)
        FETCH:  if (instr_valid && instr_ready) instr_q <= instr;
        DECODE: begin
          op_a <= regs[rs1];
          op_b <= regs[rs2];
        end
        EXEC: begin
          if (op <= OP_ADDI) zero_q <= (alu_res[DATA_WIDTH-1:0] == '0);
          if ((op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI)) carry_q <= alu_res[DATA_WIDTH];
          if ((op <= OP_ADDI) || (op == OP_MOVI)) result_q <= alu_res[DATA_WIDTH-1:0];
        end
        MEM:    result_q <= (op == OP_LD) ? mem[mem_addr] : op_b;
        WB:     if (wr_en) regs[rd] <= result_q;
        HALT:   halt_seen <= 1'b1;
        default: ;
      endcase
    end
  end

  // Data memory is deliberately not reset; a store lands on its MEM edge.
  always_ff @(posedge clk) begin
    if ((state == MEM) && (op == OP_ST)) mem[mem_addr] <= op_b;
  end

  assign dbg_data  = regs[dbg_sel];
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed program plus randomized instruction stream, checked
// against an instruction-level model of registers, memory, flags and retire latency.
module tb_multicycle_cpu;
  import cpu_pkg::*;

  localparam int DW   = 8;
  localparam int AB   = 5;
  localparam int RB   = 2;
  localparam int IW   = 4 + 3 * RB + DW;
  localparam int NREG = 4;
  localparam int NMEM = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [RB-1:0] dbg_sel = '0;
  logic [DW-1:0] dbg_data, result;
  logic          retire, zero, carry, halted;
  state_t        dbg_state;

  multicycle_cpu #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .REG_BITS(RB)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .retire      (retire),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          z;
    logic          c;
    logic          halt;
    logic [2:0]    lat;
    logic [31:0]   acc;
  } exp_t;

  exp_t exp_q[$];
  int   regs_m [NREG];
  int   mem_m  [NMEM];
  int   res_m;
  bit   z_m, c_m, halted_m;
  int   n_acc = 0, n_ret = 0;
  int   n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
    return {4'(op), 2'(rd), 2'(rs1), 2'(rs2), 8'(imm)};
  endfunction

  // Instruction-level reference: applies the architectural effect at acceptance time
  task automatic model_accept(input logic [IW-1:0] w);
    int op, rd, rs1, rs2, imm, a, b, y, addr;
    bit wr;
    exp_t e;
    op  = int'(w[IW-1 -: 4]);
    rd  = int'(w[IW-5 -: 2]);
    rs1 = int'(w[IW-7 -: 2]);
    rs2 = int'(w[IW-9 -: 2]);
    imm = int'(w[7:0]);
    a = regs_m[rs1];
    b = regs_m[rs2];
    y = res_m;
    wr = 1'b0;
    e = '0;
    e.lat = 3;
    case (op)
      0:  begin y = (a + b) % 256; c_m = ((a + b) >= 256); z_m = (y == 0); wr = 1; end
      1:  begin y = (a - b + 256) % 256; c_m = (a < b); z_m = (y == 0); wr = 1; end
      2:  begin y = a & b; z_m = (y == 0); wr = 1; end
      3:  begin y = a | b; z_m = (y == 0); wr = 1; end
      4:  begin y = a ^ b; z_m = (y == 0); wr = 1; end
      5:  begin y = (a << (imm % 8)) % 256; z_m = (y == 0); wr = 1; end
      6:  begin y = a >> (imm % 8); z_m = (y == 0); wr = 1; end
      7:  begin y = (a + imm) % 256; c_m = ((a + imm) >= 256); z_m = (y == 0); wr = 1; end
      8:  begin addr = (a + imm) % NMEM; y = mem_m[addr]; wr = 1; e.lat = 4; end
      9:  begin addr = (a + imm) % NMEM; mem_m[addr] = b; y = b; e.lat = 4; end
      10: begin y = imm; wr = 1; end
      15: e.halt = 1'b1;
      default: ;
    endcase
    if (wr) regs_m[rd] = y;
    res_m = y;
    e.res = DW'(y);
    e.z   = z_m;
    e.c   = c_m;
    e.acc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // scoreboard / monitor, sampling on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ready", instr_ready, 0);
        check("rst_retire", retire, 0);
        exp_q.delete();
        for (int r = 0; r < NREG; r++) regs_m[r] = 0;
        res_m = 0; z_m = 0; c_m = 0; halted_m = 0;
      end else begin
        if (exp_q.size() == 0) begin
          for (int r = 0; r < NREG; r++) begin
            dbg_sel = RB'(r);
            #1;
            check($sformatf("dbg_r%0d", r), dbg_data, regs_m[r]);
          end
          check("halted_idle", halted, halted_m);
          if (halted_m) check("halt_ready", instr_ready, 0);
        end
        if (retire) begin
          if (exp_q.size() == 0) check("spurious_retire", retire, 0);
          else begin
            e = exp_q.pop_front();
            n_ret++;
            check("ret_result", result, e.res);
            check("ret_zero", zero, e.z);
            check("ret_carry", carry, e.c);
            if (e.halt) halted_m = 1'b1;
            else check("ret_latency", cyc + 1 - e.acc, e.lat);
          end
        end
        if (instr_valid && instr_ready) begin
          check("accept_idle", exp_q.size(), 0);
          model_accept(instr);
          n_acc++;
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", instr_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_rst", instr_ready, 1);
    check("halted_after_rst", halted, 0);
    check("retire_after_rst", retire, 0);
  endtask

  task automatic send(input logic [IW-1:0] w);
    bit ok = 1'b0;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", ok, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("retire_timeout", ok, 1);
  endtask

  function automatic logic [IW-1:0] rand_instr();
    int op;
    op = $urandom_range(0, 14);
    if ($urandom_range(0, 5) == 0) op = 10;
    return enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 255));
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc0, ret0;
    do_reset(3);

    send(enc(10, 1, 0, 0, 200)); wait_idle();
    check("movi_r1", result, 200);
    send(enc(10, 2, 0, 0, 100)); wait_idle();
    send(enc(0, 3, 1, 2, 0));    wait_idle();
    check("add_result", result, 44);
    check("add_carry", carry, 1);
    check("add_zero", zero, 0);
    send(enc(1, 0, 2, 1, 0));    wait_idle();
    check("sub_result", result, 156);
    check("sub_borrow", carry, 1);
    send(enc(1, 0, 1, 1, 0));    wait_idle();
    check("sub_self_result", result, 0);
    check("sub_self_zero", zero, 1);
    check("sub_self_carry", carry, 0);
    send(enc(10, 1, 0, 0, 30));  wait_idle();
    send(enc(9, 0, 1, 2, 5));    wait_idle();
    check("st_result", result, 100);
    send(enc(8, 3, 1, 0, 5));    wait_idle();
    check("ld_result", result, 100);
    send(enc(8, 0, 0, 0, 3));    wait_idle();
    check("ld_wrap_addr3", result, 100);

    // fill every memory word so later loads have a known model value
    for (int i = 0; i < NREG; i++) begin
      send(enc(10, i, 0, 0, $urandom_range(0, 255))); wait_idle();
    end
    for (int a = 0; a < NMEM; a++) begin
      send(enc(9, 0, 0, $urandom_range(0, 3), a)); wait_idle();
    end

    // streaming with a fresh word every cycle while valid
    acc0 = n_acc;
    ret0 = n_ret;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      instr = rand_instr();
      instr_valid = ($urandom_range(0, 3) != 0);
    end
    instr_valid = 1'b0;
    wait_idle();
    check("stream_retire_count", n_ret - ret0, n_acc - acc0);
    check("stream_activity", (n_acc - acc0) > 20, 1);

    // abort an ADD in EXEC
    send(enc(10, 3, 0, 0, 77)); wait_idle();
    ret0 = n_ret;
    send(enc(0, 3, 1, 2, 0));
    @(posedge clk);
    #1;
    check("abort_in_exec", dbg_state, EXEC);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_retire", n_ret - ret0, 0);
    check("abort_result", result, 0);

    // HALT: sticky, refuses further instructions until reset
    send(enc(15, 0, 0, 0, 0)); wait_idle();
    check("halted_set", halted, 1);
    ret0 = n_ret;
    instr = enc(10, 1, 0, 0, 55);
    instr_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("halt_ready_held", instr_ready, 0);
    check("halt_no_retire", n_ret - ret0, 0);
    instr_valid = 1'b0;
    do_reset(2);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
